button_gesture_decoder: RTL and testbench

Classifies button activity into gesture events: short press, long press and double press. It sits directly downstream of the switch debouncer and consumes only its debounced level output. Each gesture is reported as a one-deep buffered event with a valid/ready handshake, so a slow consumer (menu FSM, display controller) can take events at its own pace.

---
 rtl/button_gesture_decoder.sv | 138 +++++++++++++
 tb/tb_button_gesture_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/button_gesture_decoder.sv
// Classifies a debounced button level into short, long and double press events,
// presented through a one-deep valid/ready output buffer with a sticky overflow flag.
module button_gesture_decoder #(
    parameter int unsigned LONG_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000,
    parameter int unsigned CNT_W       = 25
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       db_state,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    output logic       busy,
    output logic       overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS1,
        S_GAP,
        S_HOLD
    } state_t;

    localparam logic [1:0] EV_NONE   = 2'b00;
    localparam logic [1:0] EV_SHORT  = 2'b01;
    localparam logic [1:0] EV_LONG   = 2'b10;
    localparam logic [1:0] EV_DOUBLE = 2'b11;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_prev;
    logic               r_ev_valid;
    logic [1:0]         r_ev_code;
    logic               r_overflow;

    logic               w_rise;
    logic               w_fall;
    logic               w_emit;
    logic [1:0]         w_emit_code;
    logic               w_accept;

    assign w_rise   = db_state & ~r_prev;
    assign w_fall   = ~db_state & r_prev;
    assign w_accept = r_ev_valid & ev_ready;

    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_emit_code  = EV_NONE;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_next_state = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (w_fall) begin
                    w_next_state = S_GAP;
                end else if (r_cnt == LONG_LAST) begin
                    w_emit       = 1'b1;
                    w_emit_code  = EV_LONG;
                    w_next_state = S_HOLD;
                end
            end
            S_GAP: begin
                // Gap expiry wins over a coincident rise, which then starts a fresh gesture.
                if (r_cnt == GAP_LAST) begin
                    w_emit       = 1'b1;
                    w_emit_code  = EV_SHORT;
                    w_next_state = w_rise ? S_PRESS1 : S_IDLE;
                end else if (w_rise) begin
                    w_emit       = 1'b1;
                    w_emit_code  = EV_DOUBLE;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_fall) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_next_state != r_state) begin
            w_cnt_next = '0;
        end else if (r_state == S_PRESS1 || r_state == S_GAP) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_prev  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_prev  <= db_state;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ev_valid <= 1'b0;
            r_ev_code  <= EV_NONE;
            r_overflow <= 1'b0;
        end else begin
            if (w_emit && (!r_ev_valid || ev_ready)) begin
                r_ev_valid <= 1'b1;
                r_ev_code  <= w_emit_code;
            end else if (w_emit) begin
                r_overflow <= 1'b1;
            end else if (w_accept) begin
                r_ev_valid <= 1'b0;
                r_ev_code  <= EV_NONE;
            end
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_code  = r_ev_code;
    assign busy     = (r_state != S_IDLE);
    assign overflow = r_overflow;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Scoreboard bench: random press/release segments are classified into expected
// events (code and emit cycle) from the gesture rules; a monitor checks each handshake.
module tb_button_gesture_decoder;

    localparam int unsigned L = 8;
    localparam int unsigned G = 5;
    localparam int unsigned W = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       db_state = 1'b1;
    logic       ev_ready = 1'b1;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       busy;
    logic       overflow;

    button_gesture_decoder #(
        .LONG_CYCLES(L),
        .GAP_CYCLES (G),
        .CNT_W      (W)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .db_state(db_state),
        .ev_ready(ev_ready),
        .ev_valid(ev_valid),
        .ev_code (ev_code),
        .busy    (busy),
        .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input logic [1:0] code, input int at);
        ev_t e;
        e.code = code;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every handshake must match the oldest expected event.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (!ev_valid) begin
                check("code_while_invalid", int'(ev_code), 0);
            end else if (ev_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got code %0d at cycle %0d expected none", ev_code, cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("ev_code", int'(ev_code), int'(e.code));
                    if (e.cyc >= 0) check("ev_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            db_state = v;
            @(posedge CLK);
            #1;
        end
    endtask

    // Each pair is a press of h sampled-high cycles followed by l low cycles.
    task automatic run_pairs(input int n);
        bit hold_press = 0;
        for (int i = 0; i < n; i++) begin
            int h, l, r, f;
            h = int'($urandom_range(1, 12));
            l = (i == n - 1) ? 12 : int'($urandom_range(1, 8));
            r = cyc + 1;
            f = r + h;
            if (hold_press) begin
                hold_press = 0;
            end else if (h >= int'(L) + 1) begin
                push_ev(2'b10, r + int'(L));
            end else if (l < int'(G)) begin
                push_ev(2'b11, f + l);
                hold_press = 1;
            end else begin
                push_ev(2'b01, f + int'(G));
            end
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ev_valid", int'(ev_valid), 0);
        check("rst_ev_code", int'(ev_code), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);

        RST_N = 1'b1;
        drive(1'b1, 20);
        check("held_through_reset_busy", int'(busy), 0);
        check("held_through_reset_valid", int'(ev_valid), 0);
        drive(1'b0, 10);
        check("release_after_reset_valid", int'(ev_valid), 0);

        run_pairs(40);

        // Backpressure: short is buffered, the following long is dropped.
        ev_ready = 1'b0;
        push_ev(2'b01, -1);
        drive(1'b1, 2);
        drive(1'b0, 10);
        drive(1'b1, 10);
        check("bp_busy_in_hold", int'(busy), 1);
        drive(1'b0, 3);
        check("bp_ev_valid", int'(ev_valid), 1);
        check("bp_ev_code", int'(ev_code), 1);
        check("bp_overflow", int'(overflow), 1);
        ev_ready = 1'b1;
        @(posedge CLK);
        #1;
        ev_ready = 1'b0;
        check("bp_valid_after_accept", int'(ev_valid), 0);
        check("bp_overflow_sticky", int'(overflow), 1);
        ev_ready = 1'b1;
        drive(1'b0, 3);

        // Reset mid-press: counter has reached 4 when RST_N drops.
        drive(1'b1, 5);
        check("midpress_busy", int'(busy), 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("midrst_ev_valid", int'(ev_valid), 0);
        check("midrst_ev_code", int'(ev_code), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_overflow", int'(overflow), 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        drive(1'b1, 12);
        check("post_rst_busy", int'(busy), 0);
        drive(1'b0, 10);
        check("post_rst_valid", int'(ev_valid), 0);

        check("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
